pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: single-outstanding instruction fetch controller.
// Issues one fetch at a time to instruction memory, holds the returned
// word for decode, and follows taken-jump redirects from execute. A
// redirect that arrives while a fetch is in flight marks that fetch as
// stale (kill) and remembers the new target (pend_pc) so the in-flight
// handshake completes undisturbed before refetching.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory request channel
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  // instruction memory response channel
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  // decode side
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  // redirect from execute
  input  logic        redirect_valid,
  input  logic [2:0]  redirect_src,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] redirect_imm
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [2:0] NPC_J_OFFSET = 3'b001;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        req_valid_q, req_valid_d;
  logic        inst_valid_q, inst_valid_d;

  logic        redirect_eff;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;

  // Only a jump-offset redirect changes the fetch stream; targets wrap mod 2^32.
  assign redirect_eff    = redirect_valid && (redirect_src == NPC_J_OFFSET);
  assign redirect_target = redirect_pc + redirect_imm;
  assign pc_plus4        = pc_q + 32'd4;

  // Next-state logic: state transitions plus registered output values.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    pend_pc_d    = pend_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    req_valid_d  = req_valid_q;
    inst_valid_d = inst_valid_q;

    case (state_q)
      S_IDLE: begin
        state_d     = S_REQ;
        req_valid_d = 1'b1;
        if (redirect_eff) begin
          pc_d = redirect_target;
        end
      end

      S_REQ: begin
        // A redirect here cannot retract the presented address; it is
        // remembered and applied once the stale response comes back.
        if (redirect_eff) begin
          kill_d    = 1'b1;
          pend_pc_d = redirect_target;
        end
        if (imem_req_ready) begin
          state_d     = S_WAIT;
          req_valid_d = 1'b0;
        end
      end

      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (redirect_eff) begin
            pc_d        = redirect_target;
            kill_d      = 1'b0;
            state_d     = S_REQ;
            req_valid_d = 1'b1;
          end else if (kill_q) begin
            pc_d        = pend_pc_q;
            kill_d      = 1'b0;
            state_d     = S_REQ;
            req_valid_d = 1'b1;
          end else begin
            inst_d       = imem_rsp_data;
            inst_pc_d    = pc_q;
            state_d      = S_HOLD;
            inst_valid_d = 1'b1;
          end
        end else if (redirect_eff) begin
          kill_d    = 1'b1;
          pend_pc_d = redirect_target;
        end
      end

      S_HOLD: begin
        // Redirect outranks consumption: the held word is on a dead path.
        if (redirect_eff) begin
          pc_d         = redirect_target;
          state_d      = S_REQ;
          req_valid_d  = 1'b1;
          inst_valid_d = 1'b0;
        end else if (inst_ready) begin
          pc_d         = pc_plus4;
          state_d      = S_REQ;
          req_valid_d  = 1'b1;
          inst_valid_d = 1'b0;
        end
      end

      default: begin
        state_d      = S_IDLE;
        req_valid_d  = 1'b0;
        inst_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      pend_pc_q    <= 32'h0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      pend_pc_q    <= pend_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // pc only changes outside REQ, so the address is stable while presented.
  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scenario tasks plus a randomized run checked
// against a transaction-level model of the fetch stream.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [2:0]  redirect_src;
  logic [31:0] redirect_pc;
  logic [31:0] redirect_imm;

  int errors = 0;
  int checks = 0;

  pc_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_src   (redirect_src),
    .redirect_pc    (redirect_pc),
    .redirect_imm   (redirect_imm)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address, never zero at 0.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_src   = 3'b000;
    redirect_pc    = 32'h0;
    redirect_imm   = 32'h0;
  endtask

  // Leaves rst released just after an edge: the following cycle is IDLE.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_redirect(input logic [2:0] src, input logic [31:0] pc, input logic [31:0] imm);
    redirect_valid = 1'b1;
    redirect_src   = src;
    redirect_pc    = pc;
    redirect_imm   = imm;
  endtask

  // Redirect traffic with any source other than jump-offset.
  task automatic set_noise();
    int s;
    s = $urandom_range(0, 6);
    set_redirect((s == 0) ? 3'b000 : 3'(s + 1), $urandom, $urandom);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC); end
    checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h/%h exp=0/0", inst, inst_pc); end
    cyc();
    rst = 1'b0;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_req_valid got=%b exp=0", imem_req_valid); end
    $display("reset: outputs cleared");
  endtask

  // Ready memory, 1-cycle response, decode always ready; optional no-op redirects.
  task automatic test_sequential(input bit noise);
    logic [31:0] a;
    do_reset();
    if (noise) set_noise();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = 32'(k * 4);
      cyc();
      if (noise) set_noise();
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== a) begin errors++; $display("FAIL seq_req k=%0d got=%b/%h exp=1/%h", k, imem_req_valid, imem_addr, a); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL seq_inst_low_req k=%0d got=%b exp=0", k, inst_valid); end
      cyc();
      if (noise) set_noise();
      checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL seq_wait k=%0d got=%b/%b exp=0/0", k, imem_req_valid, inst_valid); end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(a);
      cyc();
      if (noise) set_noise();
      imem_rsp_valid = 1'b0;
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL seq_inst_valid k=%0d got=%b exp=1", k, inst_valid); end
      checks++; if (inst_pc !== a) begin errors++; $display("FAIL seq_inst_pc k=%0d got=%h exp=%h", k, inst_pc, a); end
      checks++; if (inst !== mem_word(a)) begin errors++; $display("FAIL seq_inst k=%0d got=%h exp=%h", k, inst, mem_word(a)); end
      $display("seq noise=%0d: fetched pc=%h inst=%h", noise, inst_pc, inst);
    end
    idle_inputs();
  endtask

  task automatic test_stall_redirect();
    do_reset();
    cyc();
    for (int c = 1; c <= 3; c++) begin
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL stall_addr c=%0d got=%b/%h exp=1/0", c, imem_req_valid, imem_addr); end
      if (c == 2) set_redirect(3'b001, 32'h10, 32'h20);
      else redirect_valid = 1'b0;
      cyc();
    end
    redirect_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL stall_addr_final got=%b/%h exp=1/0", imem_req_valid, imem_addr); end
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mem_word(32'h0);
    cyc();
    imem_rsp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stall_discard got=%b exp=0", inst_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h30) begin errors++; $display("FAIL stall_refetch got=%b/%h exp=1/00000030", imem_req_valid, imem_addr); end
    $display("stall redirect: refetch addr=%h", imem_addr);
    idle_inputs();
  endtask

  task automatic test_hold_redirect();
    do_reset();
    set_redirect(3'b001, 32'h40, 32'h0);
    cyc();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL idle_redirect got=%h exp=00000040", imem_addr); end
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mem_word(32'h40);
    cyc();
    imem_rsp_valid = 1'b0;
    cyc();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst !== mem_word(32'h40)) begin errors++; $display("FAIL hold_stable got=%b/%h/%h exp=1/00000040/%h", inst_valid, inst_pc, inst, mem_word(32'h40)); end
    set_redirect(3'b001, 32'h40, 32'hFFFF_FFF0);
    inst_ready = 1'b1;
    cyc();
    idle_inputs();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL hold_drop got=%b exp=0", inst_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h30) begin errors++; $display("FAIL hold_redirect_addr got=%b/%h exp=1/00000030", imem_req_valid, imem_addr); end
    $display("hold redirect: next fetch addr=%h", imem_addr);
  endtask

  task automatic test_wrap();
    do_reset();
    set_redirect(3'b001, 32'hFFFF_FFF0, 32'hC);
    cyc();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_start got=%h exp=fffffffc", imem_addr); end
    imem_req_ready = 1'b1;
    cyc();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mem_word(32'hFFFF_FFFC);
    cyc();
    imem_rsp_valid = 1'b0;
    checks++; if (inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_inst_pc got=%h exp=fffffffc", inst_pc); end
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got=%b/%h exp=1/00000000", imem_req_valid, imem_addr); end
    cyc();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mem_word(32'h0);
    cyc();
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    // Asynchronous reset from HOLD must clear the held word immediately.
    #2;
    rst = 1'b1;
    #1;
    checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL async_reset_hold got=%b/%h/%h exp=0/0/0", inst_valid, inst, inst_pc); end
    cyc();
    rst = 1'b0;
    $display("wrap: fetch after fffffffc went to 00000000");
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    cyc();
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || imem_addr !== RESET_PC) begin errors++; $display("FAIL wait_reset got=%b/%h exp=0/%h", imem_req_valid, imem_addr, RESET_PC); end
    cyc();
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    cyc();
    imem_rsp_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== RESET_PC || inst_valid !== 1'b0) begin errors++; $display("FAIL late_rsp got=%b/%h/%b exp=1/%h/0", imem_req_valid, imem_addr, inst_valid, RESET_PC); end
    cyc();
    checks++; if (imem_req_valid !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL late_rsp_hold got=%b/%b exp=1/0", imem_req_valid, inst_valid); end
    $display("reset in wait: first fetch addr=%h", imem_addr);
    idle_inputs();
  endtask

  // Random traffic vs. a model of the fetch stream: which address the
  // presented request must carry, and which fetch (if any) decode must see.
  task automatic test_random();
    bit          m_idle, m_req, m_inst, m_wait, m_stale;
    logic [31:0] m_addr, m_redir, m_hold, tgt;
    bit          eff, n_req, n_inst;
    int          dly;
    int          delivered;
    do_reset();
    m_idle = 1; m_req = 0; m_inst = 0; m_wait = 0; m_stale = 0;
    m_addr = RESET_PC; m_redir = 32'h0; m_hold = 32'h0; dly = 0; delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      checks++; if (imem_req_valid !== m_req) begin errors++; $display("FAIL rnd_req_valid c=%0d got=%b exp=%b", c, imem_req_valid, m_req); end
      if (m_req) begin
        checks++; if (imem_addr !== m_addr) begin errors++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, imem_addr, m_addr); end
      end
      checks++; if (inst_valid !== m_inst) begin errors++; $display("FAIL rnd_inst_valid c=%0d got=%b exp=%b", c, inst_valid, m_inst); end
      if (m_inst) begin
        checks++; if (inst_pc !== m_hold || inst !== mem_word(m_hold)) begin errors++; $display("FAIL rnd_inst c=%0d got=%h/%h exp=%h/%h", c, inst_pc, inst, m_hold, mem_word(m_hold)); end
      end

      imem_req_ready = ($urandom_range(0, 9) < 6);
      inst_ready     = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 9) < 2);
      redirect_src   = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom_range(0, 7));
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'($urandom);
      redirect_imm   = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 16));
      if (m_wait && dly == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(m_addr);
      end else if (!m_wait) begin
        imem_rsp_valid = ($urandom_range(0, 19) == 0);
        imem_rsp_data  = $urandom;
      end else begin
        imem_rsp_valid = 1'b0;
      end

      eff = redirect_valid && (redirect_src == 3'b001);
      tgt = redirect_pc + redirect_imm;
      n_req = 0;
      n_inst = 0;
      if (m_idle) begin
        m_idle = 0;
        n_req = 1;
        if (eff) m_addr = tgt;
      end else if (m_req) begin
        if (eff) begin m_stale = 1; m_redir = tgt; end
        if (imem_req_ready) begin m_wait = 1; dly = $urandom_range(0, 2); end
        else n_req = 1;
      end else if (m_wait) begin
        if (dly == 0) begin
          m_wait = 0;
          if (eff) begin m_addr = tgt; m_stale = 0; n_req = 1; end
          else if (m_stale) begin m_addr = m_redir; m_stale = 0; n_req = 1; end
          else begin m_hold = m_addr; n_inst = 1; delivered++; end
        end else begin
          dly--;
          if (eff) begin m_stale = 1; m_redir = tgt; end
        end
      end else if (m_inst) begin
        if (eff) begin m_addr = tgt; n_req = 1; end
        else if (inst_ready) begin m_addr = m_hold + 32'd4; n_req = 1; end
        else n_inst = 1;
      end
      m_req  = n_req;
      m_inst = n_inst;
      cyc();
    end
    idle_inputs();
    $display("random: %0d instructions delivered", delivered);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_sequential(1'b0);
    test_sequential(1'b1);
    test_stall_redirect();
    test_hold_redirect();
    test_wrap();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
